lcd_spi_sequencer: RTL
======================

# lcd_spi_sequencer

Byte-level command sequencer for the MI-LCD serial interface on GPIO_0. It accepts command, data and delay entries from the Nios II system over a valid/ready stream. It serializes bytes as SPI mode 0 (MSB first) on LCD_WR_SCLK / LCD_SDI, frames them with LCD_CS, and drives the data/command select on LCD_RS_HSD. Delay entries provide panel power-up and sleep-out waits, so a host-side init table can be replayed without software timing.

## Interface
- CLK_DIV, 4: SCLK half-period in clk cycles; legal range 1..255.
- CS_GAP, 2: cycles lcd_cs_n is held high after a frame-terminating byte; legal range 1..255.
- DELAY_UNIT, 50000: clk cycles per delay unit (1 ms at 50 MHz).
- clk_clk  in  1  system clock; all logic on the rising edge.
- reset_reset_n  in  1  synchronous, active-low reset.
- cmd_valid  in  1  entry present.
- cmd_ready  out  1  entry accepted on the edge where cmd_valid && cmd_ready.
- cmd_type  in  2  entry type: 00 command byte (dc=0), 01 data byte (dc=1), 10 delay, 11 reserved.
- cmd_last  in  1  byte entries only: deassert CS after this byte.
- cmd_data  in  8  byte value, or delay count in DELAY_UNITs.
- lcd_sclk  out  1  SPI clock (LCD_WR_SCLK); idles low.
- lcd_cs_n  out  1  chip select (LCD_CS), active low.
- lcd_mosi  out  1  serial data (LCD_SDI).
- lcd_dc  out  1  data/command select (LCD_RS_HSD).
- busy  out  1  high whenever state != IDLE.

## Operation
- States: IDLE, SHIFT, GAP, DELAY.
- cmd_ready = (state == IDLE), combinational. The input fields are sampled only on the accept edge.
- IDLE, accept of a byte (type 00/01):
  - Latch data and last; set lcd_dc = cmd_type[0] and lcd_cs_n = 0.
  - Set lcd_mosi = cmd_data[7]; clear the divider and bit counters; go SHIFT.
- SHIFT:
  - The divider counts 0..CLK_DIV-1. lcd_sclk toggles on each wrap, giving 16 toggles per byte.
  - On each falling toggle (except the 8th), lcd_mosi takes the next bit, MSB first.
  - After the 16th toggle, lcd_sclk is low. If last, go GAP; otherwise return to IDLE with lcd_cs_n still 0.
- GAP: lcd_cs_n = 1 for CS_GAP cycles, then IDLE.
- Delay (type 10): go DELAY for max(1, cmd_data*DELAY_UNIT) cycles, then IDLE.
  - lcd_cs_n, lcd_dc, lcd_mosi and lcd_sclk are unchanged during the delay.
  - The counter is wide enough for 255*DELAY_UNIT.
- Reserved (type 11): accepted and dropped; state stays IDLE with no output change.
- lcd_dc changes only on an accept edge. It is therefore never changed while lcd_sclk is high.
- Multi-byte frames: CS stays low across consecutive non-last bytes. lcd_sclk stays low between them, for any idle time the host inserts.

## Timing
- Reset: lcd_sclk=0, lcd_cs_n=1, lcd_mosi=0, lcd_dc=0, busy=0, state=IDLE, so cmd_ready=1 the cycle after reset. All counters are cleared.
- Reset mid-byte or mid-delay aborts immediately: lcd_cs_n=1 and lcd_sclk=0 on the reset edge. No partial byte resumes.
- Take the accept edge as cycle 0:
  - From cycle 1: lcd_cs_n=0, lcd_mosi=bit7, lcd_sclk=0.
  - Rising SCLK edge k (k=0..7) occurs at cycle 1+CLK_DIV*(2k+1).
  - Falling SCLK edge k occurs at cycle 1+CLK_DIV*(2k+2).
- Ready timing after a byte:
  - Non-last byte: cmd_ready returns at cycle 1+16*CLK_DIV (65 for CLK_DIV=4).
  - Last byte: lcd_cs_n rises at cycle 1+16*CLK_DIV; cmd_ready returns at cycle 1+16*CLK_DIV+CS_GAP.
- Delay: cmd_ready returns at cycle 1+max(1, N*DELAY_UNIT).
- Back-to-back throughput: with cmd_valid held high, a new byte is accepted on the first cycle in IDLE, with zero bubble beyond the above.

## Test plan
- Reset: hold reset_reset_n=0 for 3 cycles then release -> lcd_cs_n=1, lcd_sclk=0, lcd_mosi=0, lcd_dc=0, busy=0, cmd_ready=1 on the first cycle after release.
- Single command 0x2A, last=1, CLK_DIV=4, CS_GAP=2:
  - lcd_mosi sampled at the 8 rising edges = 0,0,1,0,1,0,1,0 at cycles 5,13,…,61.
  - lcd_dc=0 throughout; lcd_cs_n rises at cycle 65; cmd_ready at cycle 67.
- Frame 0x2C (cmd, last=0), then 0xFF, 0x00 (data, last=1 on 0x00), cmd_valid held:
  - lcd_cs_n stays low across all 24 bits; exactly 24 rising edges.
  - lcd_dc rises only on the second accept edge, with lcd_sclk low.
- Delay 3 with DELAY_UNIT=10, CS low from a prior non-last byte -> cmd_ready low for exactly 30 cycles; lcd_cs_n stays 0; no lcd_sclk toggles.
- Assert reset at cycle 20 of a byte -> lcd_cs_n=1 and lcd_sclk=0 on the reset edge. After release, the next byte 0xA5 shifts complete and correct.
- Reserved type 11 with data 0x55 -> accepted in one cycle, no pin activity, busy stays 0. Delay with data 0 -> busy high for exactly 1 cycle.

Source files
------------

// File: rtl/lcd_spi_sequencer.sv
// Command/data/delay sequencer for the MI-LCD serial port: SPI mode 0, MSB first, CS framing.
// The host replays an init table as a stream of entries; delay entries stall the stream.
module lcd_spi_sequencer #(
  parameter int CLK_DIV    = 4,
  parameter int CS_GAP     = 2,
  parameter int DELAY_UNIT = 50000
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_type,
  input  logic       cmd_last,
  input  logic [7:0] cmd_data,
  output logic       lcd_sclk,
  output logic       lcd_cs_n,
  output logic       lcd_mosi,
  output logic       lcd_dc,
  output logic       busy
);
  // Handshake: an entry transfers on the rising edge where cmd_valid && cmd_ready. cmd_ready is
  // high exactly while IDLE, and cmd_type/cmd_last/cmd_data are only sampled on that edge.

  localparam int               DLY_W    = $clog2(255 * DELAY_UNIT + 1);
  localparam logic [7:0]       DIV_MAX  = 8'(CLK_DIV - 1);
  localparam logic [DLY_W-1:0] UNIT     = DLY_W'(DELAY_UNIT);
  localparam logic [DLY_W-1:0] GAP_LOAD = DLY_W'(CS_GAP - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DELAY = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       div_q, div_d;
  logic [3:0]       tog_q, tog_d;
  logic [6:0]       sh_q, sh_d;
  logic             last_q, last_d;
  logic [DLY_W-1:0] cnt_q, cnt_d;
  logic             sclk_q, sclk_d;
  logic             cs_n_q, cs_n_d;
  logic             mosi_q, mosi_d;
  logic             dc_q, dc_d;
  logic [DLY_W-1:0] dly_total;

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      tog_q   <= '0;
      sh_q    <= '0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
      sclk_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      mosi_q  <= 1'b0;
      dc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      tog_q   <= tog_d;
      sh_q    <= sh_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      sclk_q  <= sclk_d;
      cs_n_q  <= cs_n_d;
      mosi_q  <= mosi_d;
      dc_q    <= dc_d;
    end
  end

  always_comb begin
    dly_total = DLY_W'(cmd_data) * UNIT;
    state_d   = state_q;
    div_d     = div_q;
    tog_d     = tog_q;
    sh_d      = sh_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    sclk_d    = sclk_q;
    cs_n_d    = cs_n_q;
    mosi_d    = mosi_q;
    dc_d      = dc_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          case (cmd_type)
            2'b00, 2'b01: begin
              sh_d    = cmd_data[6:0];
              last_d  = cmd_last;
              dc_d    = cmd_type[0];
              cs_n_d  = 1'b0;
              mosi_d  = cmd_data[7];
              div_d   = '0;
              tog_d   = '0;
              state_d = SHIFT;
            end
            2'b10: begin
              // A zero count still costs one cycle so every delay entry is visible as busy.
              cnt_d   = (dly_total == '0) ? '0 : dly_total - DLY_W'(1);
              state_d = DELAY;
            end
            default: ;
          endcase
        end
      end
      SHIFT: begin
        if (div_q == DIV_MAX) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          tog_d  = tog_q + 4'd1;
          if (sclk_q && (tog_q != 4'd15)) begin
            mosi_d = sh_q[6];
            sh_d   = {sh_q[5:0], 1'b0};
          end
          if (tog_q == 4'd15) begin
            if (last_q) begin
              cs_n_d  = 1'b1;
              cnt_d   = GAP_LOAD;
              state_d = GAP;
            end else begin
              state_d = IDLE;
            end
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      GAP, DELAY: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - DLY_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == IDLE);
    busy      = (state_q != IDLE);
    lcd_sclk  = sclk_q;
    lcd_cs_n  = cs_n_q;
    lcd_mosi  = mosi_q;
    lcd_dc    = dc_q;
  end
endmodule
